// File: rtl/mole_game_engine.sv
// Whack-a-mole game core: N_MOLES holes, bounded concurrent moles, per-hole lifetimes, round timer.
// Optional build macro MOLE_MISS_PENALTY_EN: strikes on unlit holes cost one point each.
module mole_game_engine #(
    parameter int N_MOLES     = 9,
    parameter int MAX_ACTIVE  = 3,
    parameter int CLKS_PER_MS = 50000,
    parameter int LIFE_MS     = 1600,
    parameter int SPAWN_MS    = 800,
    parameter int GAME_S      = 60,
    parameter int SCORE_W     = 16,
    parameter int RNG_W       = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         difficulty,
    input  logic [N_MOLES-1:0] whack,
    input  logic [RNG_W-1:0]   random_value,
    output logic [N_MOLES-1:0] mole_positions,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         time_left,
    output logic [1:0]         game_state
);

    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    localparam int IDX_W   = $clog2(N_MOLES);
    localparam int CNT_W   = $clog2(N_MOLES + 1);
    localparam int PRE_W   = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int LIFE_W  = $clog2(LIFE_MS + 1);
    localparam int SPAWN_W = $clog2(SPAWN_MS + 1);
    localparam int SUM_W   = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 2;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLKS_PER_MS - 1);
    localparam logic [IDX_W:0]    N_LIM     = (IDX_W + 1)'(N_MOLES);
    localparam logic [CNT_W-1:0]  ACT_LIM   = CNT_W'(MAX_ACTIVE);
    localparam logic [SUM_W-1:0]  SCORE_MAX = SUM_W'((64'd1 << SCORE_W) - 64'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           diff_q, diff_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [9:0]           msec_q, msec_d;
    logic [7:0]           time_q, time_d;
    logic [SPAWN_W-1:0]   spawn_q, spawn_d;
    logic [N_MOLES-1:0]   mole_q, mole_d;
    logic [LIFE_W-1:0]    life_q [N_MOLES];
    logic [LIFE_W-1:0]    life_d [N_MOLES];
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [N_MOLES-1:0]   sync1_q, sync2_q, prev_q;

    logic [N_MOLES-1:0]   strike;
    logic [IDX_W-1:0]     idx;
    logic                 idx_ok;
    logic                 ms_tick;
    logic                 spawn_fire;
    logic [SPAWN_W-1:0]   spawn_int;
    logic [LIFE_W-1:0]    life_int;
    logic [CNT_W-1:0]     hit_cnt;
    logic [CNT_W-1:0]     active_cnt;
    logic [SUM_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_next;
`ifdef MOLE_MISS_PENALTY_EN
    logic [CNT_W-1:0]     miss_cnt;
`endif

    // Only the low index bits pick a hole; the rest of the RNG word is deliberately dropped.
    generate
        if (RNG_W > IDX_W) begin : g_rng_hi
            logic unused_rng_hi;
            assign unused_rng_hi = ^random_value[RNG_W-1:IDX_W];
        end
    endgenerate

    assign strike     = sync2_q ^ prev_q;
    assign idx        = random_value[IDX_W-1:0];
    assign idx_ok     = ({1'b0, idx} < N_LIM);
    assign spawn_fire = (spawn_q == spawn_int - 1'b1);

    always_comb begin
        spawn_int = SPAWN_W'(at_least_one(SPAWN_MS));
        life_int  = LIFE_W'(at_least_one(LIFE_MS));
        case (diff_q)
            2'd1: begin
                spawn_int = SPAWN_W'(at_least_one(SPAWN_MS >> 1));
                life_int  = LIFE_W'(at_least_one(LIFE_MS >> 1));
            end
            2'd2: begin
                spawn_int = SPAWN_W'(at_least_one(SPAWN_MS >> 2));
                life_int  = LIFE_W'(at_least_one(LIFE_MS >> 2));
            end
            2'd3: begin
                spawn_int = SPAWN_W'(at_least_one(SPAWN_MS >> 3));
                life_int  = LIFE_W'(at_least_one(LIFE_MS >> 3));
            end
            default: ;
        endcase
    end

    // Hits and misses are judged against the registered mole map, before spawn/expiry.
    always_comb begin
        hit_cnt    = '0;
        active_cnt = '0;
`ifdef MOLE_MISS_PENALTY_EN
        miss_cnt   = '0;
`endif
        for (int i = 0; i < N_MOLES; i++) begin
            hit_cnt    = hit_cnt + CNT_W'(strike[i] & mole_q[i]);
            active_cnt = active_cnt + CNT_W'(mole_q[i]);
`ifdef MOLE_MISS_PENALTY_EN
            miss_cnt   = miss_cnt + CNT_W'(strike[i] & ~mole_q[i]);
`endif
        end
        score_sum = SUM_W'(score_q) + SUM_W'(hit_cnt);
`ifdef MOLE_MISS_PENALTY_EN
        if (score_sum < SUM_W'(miss_cnt)) begin
            score_sum = '0;
        end else begin
            score_sum = score_sum - SUM_W'(miss_cnt);
        end
`endif
        if (score_sum > SCORE_MAX) begin
            score_sum = SCORE_MAX;
        end
        score_next = score_sum[SCORE_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        diff_d  = diff_q;
        pre_d   = pre_q;
        msec_d  = msec_q;
        time_d  = time_q;
        spawn_d = spawn_q;
        mole_d  = mole_q;
        life_d  = life_q;
        score_d = score_q;
        ms_tick = 1'b0;

        if (state_q == ST_PLAY) begin
            if (time_q == 8'd0) begin
                state_d = ST_OVER;
                mole_d  = '0;
                for (int i = 0; i < N_MOLES; i++) life_d[i] = '0;
            end else begin
                ms_tick = (pre_q == PRE_LAST);
                pre_d   = ms_tick ? '0 : pre_q + 1'b1;
                score_d = score_next;
                if (ms_tick) begin
                    if (msec_q == 10'd999) begin
                        msec_d = '0;
                        time_d = time_q - 8'd1;
                    end else begin
                        msec_d = msec_q + 10'd1;
                    end
                    spawn_d = spawn_fire ? '0 : spawn_q + 1'b1;
                end
                for (int i = 0; i < N_MOLES; i++) begin
                    if (mole_q[i]) begin
                        if (strike[i] || (ms_tick && life_q[i] <= LIFE_W'(1))) begin
                            mole_d[i] = 1'b0;
                            life_d[i] = '0;
                        end else if (ms_tick) begin
                            life_d[i] = life_q[i] - 1'b1;
                        end
                    end
                end
                if (ms_tick && spawn_fire && idx_ok && !mole_q[idx] && (active_cnt < ACT_LIM)) begin
                    mole_d[idx] = 1'b1;
                    life_d[idx] = life_int;
                end
            end
        end

        // A start pulse overrides every other update, in any state.
        if (start) begin
            state_d = ST_PLAY;
            diff_d  = difficulty;
            pre_d   = '0;
            msec_d  = '0;
            time_d  = 8'(GAME_S);
            spawn_d = '0;
            mole_d  = '0;
            score_d = '0;
            for (int i = 0; i < N_MOLES; i++) life_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            diff_q  <= '0;
            pre_q   <= '0;
            msec_q  <= '0;
            time_q  <= '0;
            spawn_q <= '0;
            mole_q  <= '0;
            score_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            for (int i = 0; i < N_MOLES; i++) life_q[i] <= '0;
        end else begin
            state_q <= state_d;
            diff_q  <= diff_d;
            pre_q   <= pre_d;
            msec_q  <= msec_d;
            time_q  <= time_d;
            spawn_q <= spawn_d;
            mole_q  <= mole_d;
            score_q <= score_d;
            sync1_q <= whack;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            for (int i = 0; i < N_MOLES; i++) life_q[i] <= life_d[i];
        end
    end

    assign mole_positions = mole_q;
    assign score          = score_q;
    assign time_left      = time_q;
    assign game_state     = state_q;

endmodule

// File: tb/tb_mole_game_engine.sv
// Bench for mole_game_engine: small timing parameters, a 2-bit score so saturation is reachable,
// an event-level reference model compared every cycle, plus hand-computed directed checks.
module tb_mole_game_engine;

    localparam int N     = 9;
    localparam int MAXA  = 3;
    localparam int CPM   = 2;
    localparam int LIFE  = 8;
    localparam int SPAWN = 4;
    localparam int GS    = 2;
    localparam int SW    = 2;
    localparam int SMAX  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    difficulty = 2'd0;
    logic [N-1:0]  whack = '0;
    logic [10:0]   rv = '0;
    logic [N-1:0]  moles;
    logic [SW-1:0] score;
    logic [7:0]    time_left;
    logic [1:0]    game_state;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

`ifdef MOLE_MISS_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    mole_game_engine #(
        .N_MOLES(N), .MAX_ACTIVE(MAXA), .CLKS_PER_MS(CPM), .LIFE_MS(LIFE),
        .SPAWN_MS(SPAWN), .GAME_S(GS), .SCORE_W(SW), .RNG_W(11)
    ) dut (
        .clk(clk), .reset(rst_n), .start(start), .difficulty(difficulty),
        .whack(whack), .random_value(rv), .mole_positions(moles),
        .score(score), .time_left(time_left), .game_state(game_state)
    );

    always #5 clk = ~clk;

    // Reference model: time is tracked as elapsed clock cycles and elapsed ms since start,
    // each lit hole remembers the ms at which it expires.
    int            m_state = 0, m_score = 0, m_time = 0, m_diff = 0;
    int            m_cyc = 0, m_ms = 0;
    logic [N-1:0]  m_moles = '0;
    int            m_expire [N];
    logic [N-1:0]  h0 = '0, h1 = '0, h2 = '0;
    logic [N-1:0]  md_strike, md_pre;
    int            md_ns, md_sp, md_life, md_idx;
    bit            md_tick;

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_score = 0; m_time = 0; m_diff = 0;
            m_cyc = 0; m_ms = 0; m_moles = '0;
            h0 = '0; h1 = '0; h2 = '0;
        end else begin
            md_strike = h1 ^ h2;
            h2 = h1; h1 = h0; h0 = whack;
            if (start) begin
                m_state = 1; m_score = 0; m_moles = '0; m_cyc = 0; m_ms = 0;
                m_time = GS; m_diff = int'(difficulty);
            end else if (m_state == 1) begin
                if (m_time == 0) begin
                    m_state = 2;
                    m_moles = '0;
                end else begin
                    md_pre = m_moles;
                    m_cyc++;
                    md_tick = (m_cyc % CPM) == 0;
                    if (md_tick) m_ms++;
                    md_ns = m_score + $countones(md_strike & md_pre);
                    if (PEN) md_ns = md_ns - $countones(md_strike & ~md_pre);
                    if (md_ns < 0) md_ns = 0;
                    if (md_ns > SMAX) md_ns = SMAX;
                    m_score = md_ns;
                    m_moles = md_pre & ~md_strike;
                    if (md_tick) begin
                        for (int i = 0; i < N; i++)
                            if (m_moles[i] && m_ms == m_expire[i]) m_moles[i] = 1'b0;
                        md_sp   = max1(SPAWN >> m_diff);
                        md_life = max1(LIFE >> m_diff);
                        md_idx  = int'(rv) % 16;
                        if ((m_ms % md_sp) == 0 && md_idx < N && !md_pre[md_idx]
                            && $countones(md_pre) < MAXA) begin
                            m_moles[md_idx]  = 1'b1;
                            m_expire[md_idx] = m_ms + md_life;
                        end
                    end
                    m_time = GS - m_ms / 1000;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            total++;
            if (moles !== m_moles || int'(score) != m_score || int'(time_left) != m_time
                || int'(game_state) != m_state) begin
                bad++;
                $display("FAIL model t=%0t: moles=%h/%h score=%0d/%0d time=%0d/%0d state=%0d/%0d (got/want)",
                         $time, moles, m_moles, score, m_score, time_left, m_time, game_state, m_state);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench one negedge after the edge (E0) that samples start.
    task automatic do_start(input int d);
        difficulty = 2'(d);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic tog(input int b);
        whack[b] = ~whack[b];
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick_n(2);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Idle after reset; strikes ignored while idle and not replayed after start
        tick_n(3);
        chk("rst_state", int'(game_state), 0);
        chk("rst_moles", int'(moles), 0);
        chk("rst_time", int'(time_left), 0);
        tog(1);
        tick_n(4);
        chk("idle_strike_score", int'(score), 0);
        rv = 11'h00F;
        do_start(0);
        chk("start_state", int'(game_state), 1);
        chk("start_time", int'(time_left), GS);
        tog(7);
        tick_n(3);
        chk("miss_at_zero", int'(score), 0);

        // Spawn after 4 ms, strike coinciding with expiry counts as a hit, plain expiry
        rv = 11'd4;
        do_start(0);
        tick_n(7);  chk("spawn_E7", int'(moles), 0);
        tick_n(1);  chk("spawn_E8", int'(moles), 'h010);
        tick_n(13); tog(4);
        tick_n(2);  chk("lit_E23", int'(moles), 'h010);
        tick_n(1);  chk("hit_expiry_moles", int'(moles), 0);
        chk("hit_expiry_score", int'(score), 1);
        tick_n(8);  chk("respawn_E32", int'(moles), 'h010);
        tick_n(15); chk("lit_E47", int'(moles), 'h010);
        tick_n(1);  chk("expire_E48", int'(moles), 0);
        chk("expire_score", int'(score), 1);

        // Hit latency of three edges; strike and spawn on the same hole
        rv = 11'd2;
        do_start(0);
        tick_n(8);  chk("hole2_lit", int'(moles), 'h004);
        tog(2);
        tick_n(2);  chk("hit_E10_moles", int'(moles), 'h004);
        chk("hit_E10_score", int'(score), 0);
        tick_n(1);  chk("hit_E11_moles", int'(moles), 0);
        chk("hit_E11_score", int'(score), 1);
        rv = 11'd6;
        tick_n(2);  tog(6);
        tick_n(3);  chk("strike_spawn_moles", int'(moles), 'h040);
        chk("strike_spawn_score", int'(score), PEN ? 0 : 1);

        // Out-of-range indices never spawn; index 8 does
        rv = 11'h01C;
        do_start(0);
        tick_n(8);  chk("idx12", int'(moles), 0);
        rv = 11'h7FF;
        tick_n(8);  chk("idx15", int'(moles), 0);
        rv = 11'd9;
        tick_n(8);  chk("idx9", int'(moles), 0);
        rv = 11'h018;
        tick_n(8);  chk("idx8", int'(moles), 'h100);

        // Simultaneous hits, saturation at 3, miss penalty, reset mid-round
        rv = 11'd0;
        do_start(0);
        tick_n(8);  chk("hole0", int'(moles), 'h001);
        rv = 11'd1;
        tick_n(8);  chk("hole01", int'(moles), 'h003);
        tog(0); tog(1);
        tick_n(3);  chk("double_hit_score", int'(score), 2);
        chk("double_hit_moles", int'(moles), 0);
        rv = 11'd3;
        tick_n(5);  chk("hole3", int'(moles), 'h008);
        tog(3);
        tick_n(3);  chk("score3", int'(score), 3);
        tick_n(5);  chk("hole3_again", int'(moles), 'h008);
        tog(3);
        tick_n(3);  chk("saturate", int'(score), 3);
        tog(7);
        tick_n(3);  chk("miss_penalty", int'(score), PEN ? 2 : 3);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_state", int'(game_state), 0);
        chk("midreset_score", int'(score), 0);
        chk("midreset_moles", int'(moles), 0);
        chk("midreset_time", int'(time_left), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_n(3);

        // Difficulty 2: spawn every ms, lifetime 2 ms
        rv = 11'd5;
        do_start(2);
        tick_n(1);  chk("d2_E1", int'(moles), 0);
        tick_n(1);  chk("d2_E2", int'(moles), 'h020);
        tick_n(3);  chk("d2_E5", int'(moles), 'h020);
        tick_n(1);  chk("d2_E6", int'(moles), 0);
        tick_n(2);  chk("d2_E8", int'(moles), 'h020);

        // Full round at difficulty 1, then game over and restart
        rv = 11'd1;
        do_start(1);
        tick_n(4);  chk("d1_spawn", int'(moles), 'h002);
        tog(1);
        tick_n(3);  chk("d1_hit", int'(score), 1);
        tick_n(1992); chk("time_E1999", int'(time_left), 2);
        tick_n(1);    chk("time_E2000", int'(time_left), 1);
        tick_n(2000); chk("time_E4000", int'(time_left), 0);
        chk("state_E4000", int'(game_state), 1);
        tick_n(1);  chk("over_state", int'(game_state), 2);
        chk("over_moles", int'(moles), 0);
        chk("over_score", int'(score), 1);
        tog(1);
        tick_n(5);  chk("over_strike_score", int'(score), 1);
        chk("over_time", int'(time_left), 0);
        do_start(0);
        chk("restart_state", int'(game_state), 1);
        chk("restart_score", int'(score), 0);
        chk("restart_time", int'(time_left), GS);
        tick_n(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
